// File: rtl/roe_pkg.sv
// Shared R.O.E core definitions: fetch FSM state, special instruction words, decode typedefs.
package roe_pkg;

  localparam int unsigned INSTR_W     = 9;
  localparam int unsigned FETCH_CNT_W = 16;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;
  localparam logic [INSTR_W-1:0] NOP_INSTR  = 9'h000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Decode-side field types used by control
  typedef enum logic [2:0] {
    OP_ALU = 3'd0,
    OP_LDI = 3'd1,
    OP_LD  = 3'd2,
    OP_ST  = 3'd3,
    OP_BR  = 3'd4,
    OP_JMP = 3'd5,
    OP_IO  = 3'd6,
    OP_SYS = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    FN_ADD = 2'd0,
    FN_SUB = 2'd1,
    FN_AND = 2'd2,
    FN_OR  = 2'd3
  } funct_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch bus: instruction ROM port plus the decode-facing instruction/stall/redirect signals.
interface fetch_unit_if #(
  parameter int unsigned PC_W = 10
);
  import roe_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid,
    input  imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid,
    output imem_rdata, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/fetch_perf_counter.sv
// Saturating event counter for delivered instructions; synchronous clear wins over increment.
module fetch_perf_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// R.O.E instruction fetch: owns the PC, drives a 1-cycle-latency ROM, handles stall/branch/halt.
// Optional FETCH_PERF_EN adds a saturating delivered-instruction counter on fetch_count.
module fetch_unit
  import roe_pkg::*;
#(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   halted,
`ifdef FETCH_PERF_EN
  output logic [FETCH_CNT_W-1:0] fetch_count,
`endif
  fetch_unit_if.master           bus
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [PC_W-1:0]    addr_c;
  logic [INSTR_W-1:0] instr_c;
  logic               hold_c;
  logic               halt_seen_c;
  logic               branch_c;

  assign instr_c     = valid_q ? bus.imem_rdata : NOP_INSTR;
  assign hold_c      = bus.stall && valid_q;
  assign halt_seen_c = valid_q && !bus.stall && (instr_c == HALT_INSTR);
  assign branch_c    = (state_q == RUN) && valid_q && !bus.stall && bus.branch_taken
                       && (instr_c != HALT_INSTR);

  // ROM address select; a stalled word is re-read so imem_rdata stays stable
  always_comb begin
    addr_c = pc_q;
    if (hold_c) begin
      addr_c = ipc_q;
    end else if (branch_c) begin
      addr_c = bus.branch_target;
    end else if ((state_q == HALT) && start) begin
      addr_c = RST_PC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RST_PC;
      ipc_q    <= RST_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          ipc_d   = pc_q;
          pc_d    = pc_q + PC_W'(1);
          valid_d = 1'b1;
        end
      end
      RUN: begin
        // Halt is checked before the advance so it beats a concurrent branch
        if (hold_c) begin
          state_d = RUN;
        end else if (halt_seen_c) begin
          state_d  = HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else begin
          ipc_d   = addr_c;
          pc_d    = addr_c + PC_W'(1);
          valid_d = 1'b1;
        end
      end
      HALT: begin
        if (start) begin
          state_d  = RUN;
          ipc_d    = RST_PC;
          pc_d     = RST_PC + PC_W'(1);
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_addr   = addr_c;
  assign bus.instr       = instr_c;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign halted          = halted_q;

`ifdef FETCH_PERF_EN
  logic start_ok_c;
  assign start_ok_c = start && ((state_q == IDLE) || (state_q == HALT));

  fetch_perf_counter #(
    .W (FETCH_CNT_W)
  ) u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok_c),
    .inc   (valid_q && !bus.stall),
    .count (fetch_count)
  );
`endif

endmodule
